// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS program-memory loader: FSM states, error codes,
// end-of-program marker and the address-width helper.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK            = 2'b00;
  localparam logic [1:0] ERR_CLEAR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW      = 2'b10;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  // Bits needed to address 'depth' entries (ceil(log2(depth))).
  function automatic int clogb2(input int depth);
    int v;
    int r;
    v = depth - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ensamblador_palabra.sv
// Byte-to-word assembler: shifts received bytes in MSB first and flags the completed word.
// Latency: o_word/o_word_vld are combinational with the final byte; state updates on that edge.
// Backpressure: none; every i_byte_vld is accepted, i_clear discards any partial word.
module ensamblador_palabra
  import mips_mem_pkg::*;
#(
  parameter int RAM_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_byte_vld,
  input  logic [7:0]           i_byte,
  output logic [RAM_WIDTH-1:0] o_word,
  output logic                 o_word_vld
);

  localparam int NBYTES = RAM_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? clogb2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [RAM_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Next word image and byte index for the byte currently presented.
  always_comb begin
    word_d = (word_q << 8) | RAM_WIDTH'(i_byte);
    idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  end

  assign o_word     = word_d;
  assign o_word_vld = i_byte_vld && !i_clear && (idx_q == LAST_IDX);

  // Shift register and byte index; a clear throws away a partially built word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_byte_vld) begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/controlador_carga_programa.sv
// Program-memory sequencer: clears the memory, loads words from the UART byte stream, then lends the port to fetch.
// Latency: memory write issued the cycle after the 4th byte; fetch path is combinational in IDLE/RUN.
// Backpressure: none; bytes are accepted at line rate, including one arriving during a write cycle.
module controlador_carga_programa
  import mips_mem_pkg::*;
#(
  parameter int                   RAM_WIDTH     = 32,
  parameter int                   RAM_DEPTH     = 2048,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD     = RAM_WIDTH'(HALT_WORD_DEF),
  parameter int                   CLEAR_TIMEOUT = 4096,
  localparam int                  ADDR_W        = clogb2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_reset_ack,
  input  logic [ADDR_W-1:0]    i_fetch_addr,
  input  logic                 i_fetch_en,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [RAM_WIDTH-1:0] o_mem_data,
  output logic                 o_mem_wea,
  output logic                 o_mem_ena,
  output logic                 o_mem_regcea,
  output logic                 o_mem_rsta,
  output logic                 o_mem_soft_reset,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic [ADDR_W:0]      o_word_count,
  output logic [1:0]           o_error
);

  localparam int                CNT_W       = clogb2(CLEAR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(CLEAR_TIMEOUT);
  localparam logic [CNT_W-1:0]  MIN_CLEAR   = CNT_W'(2);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT   = (ADDR_W+1)'(RAM_DEPTH);

  state_t               state_q;
  logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [ADDR_W:0]      word_cnt_q;
  logic [1:0]           err_q;
  logic                 soft_rst_q, wea_q, ena_q, rsta_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [RAM_WIDTH-1:0] data_q;
  logic                 loading_q, load_done_q;

  logic                 asm_clear, asm_byte_vld, word_vld, mux_sel;
  logic [RAM_WIDTH-1:0] word;

  // Bytes only count while loading; a (re)start wipes any leftover partial word.
  assign asm_byte_vld = i_rx_done && (state_q == ST_LOAD);
  assign asm_clear    = i_start && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign clr_cnt_d    = clr_cnt_q + CNT_W'(1);

  ensamblador_palabra #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_ensamblador (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (asm_clear),
    .i_byte_vld (asm_byte_vld),
    .i_byte     (i_rx_data),
    .o_word     (word),
    .o_word_vld (word_vld)
  );

  // Sequencer FSM with registered memory controls and status.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      wr_addr_q   <= '0;
      word_cnt_q  <= '0;
      err_q       <= ERR_OK;
      soft_rst_q  <= 1'b1;
      wea_q       <= 1'b0;
      ena_q       <= 1'b0;
      rsta_q      <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      loading_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      wea_q <= 1'b0;
      ena_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (i_start) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            wr_addr_q   <= '0;
            word_cnt_q  <= '0;
            err_q       <= ERR_OK;
            addr_q      <= '0;
            soft_rst_q  <= 1'b0;
            rsta_q      <= 1'b1;
            loading_q   <= 1'b1;
            load_done_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if ((clr_cnt_d >= MIN_CLEAR) && !i_reset_ack) begin
            state_q    <= ST_LOAD;
            soft_rst_q <= 1'b1;
          end else if (clr_cnt_d == TIMEOUT_CNT) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_CLEAR_TIMEOUT;
            soft_rst_q <= 1'b1;
            loading_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (word_vld) begin
            wea_q  <= 1'b1;
            ena_q  <= 1'b1;
            addr_q <= wr_addr_q;
            data_q <= word;
          end
          // Bookkeeping happens in the write cycle itself.
          if (wea_q) begin
            if (word_cnt_q != MAX_COUNT) word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
            if (wr_addr_q != LAST_ADDR) wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (data_q == HALT_WORD) begin
              state_q     <= ST_RUN;
              loading_q   <= 1'b0;
              load_done_q <= 1'b1;
            end else if (wr_addr_q == LAST_ADDR) begin
              state_q     <= ST_RUN;
              err_q       <= ERR_OVERFLOW;
              loading_q   <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Fetch owns the port in IDLE/RUN; reset forces the quiet values regardless.
  assign mux_sel = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !i_reset;

  assign o_mem_addr       = mux_sel ? i_fetch_addr : addr_q;
  assign o_mem_ena        = mux_sel ? i_fetch_en   : ena_q;
  assign o_mem_regcea     = mux_sel && i_fetch_en;
  assign o_mem_wea        = mux_sel ? 1'b0 : wea_q;
  assign o_mem_rsta       = mux_sel ? 1'b0 : rsta_q;
  assign o_mem_data       = data_q;
  assign o_mem_soft_reset = soft_rst_q;
  assign o_loading        = loading_q;
  assign o_load_done      = load_done_q;
  assign o_word_count     = word_cnt_q;
  assign o_error          = err_q;

endmodule

// File: tb/tb_controlador_carga_programa.sv
// Bench for the program-memory loader: a 2048-deep instance for the main flow and a 4-deep one for overflow.
// Memory and clear-ack behaviour are modelled here; expected writes come from a byte-stream reference model.
module tb_controlador_carga_programa;

  localparam int AWB = 11;
  localparam int AWS = 2;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, fetch_en, rx_done;
  logic [7:0]     rx_data;
  logic           start_b, ack_b, stuck_b;
  logic           start_s, ack_s;
  logic [AWB-1:0] faddr_b;
  logic [AWS-1:0] faddr_s;

  logic [AWB-1:0] addr_b;
  logic [31:0]    data_b;
  logic           wea_b, ena_b, regcea_b, rsta_b, soft_b, loading_b, done_b;
  logic [AWB:0]   wcnt_b;
  logic [1:0]     err_b;

  logic [AWS-1:0] addr_s;
  logic [31:0]    data_s;
  logic           wea_s, ena_s, regcea_s, rsta_s, soft_s, loading_s, done_s;
  logic [AWS:0]   wcnt_s;
  logic [1:0]     err_s;

  int checks = 0;
  int errors = 0;

  controlador_carga_programa dut (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_reset_ack(ack_b), .i_fetch_addr(faddr_b), .i_fetch_en(fetch_en),
    .o_mem_addr(addr_b), .o_mem_data(data_b), .o_mem_wea(wea_b), .o_mem_ena(ena_b),
    .o_mem_regcea(regcea_b), .o_mem_rsta(rsta_b), .o_mem_soft_reset(soft_b),
    .o_loading(loading_b), .o_load_done(done_b), .o_word_count(wcnt_b), .o_error(err_b)
  );

  controlador_carga_programa #(.RAM_DEPTH(4)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_start(start_s), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_reset_ack(ack_s), .i_fetch_addr(faddr_s), .i_fetch_en(fetch_en),
    .o_mem_addr(addr_s), .o_mem_data(data_s), .o_mem_wea(wea_s), .o_mem_ena(ena_s),
    .o_mem_regcea(regcea_s), .o_mem_rsta(rsta_s), .o_mem_soft_reset(soft_s),
    .o_loading(loading_s), .o_load_done(done_s), .o_word_count(wcnt_s), .o_error(err_s)
  );

  // Clear-ack model: busy on the first clear cycle, done from the second (or never when stuck).
  int clr_cyc_b = 0;
  int clr_cyc_s = 0;
  always @(posedge clk) begin
    clr_cyc_b <= soft_b ? 0 : clr_cyc_b + 1;
    clr_cyc_s <= soft_s ? 0 : clr_cyc_s + 1;
  end
  assign ack_b = !soft_b && (stuck_b || (clr_cyc_b == 0));
  assign ack_s = !soft_s && (clr_cyc_s == 0);

  // Block RAM model with a two-stage read path (array read, then output register).
  logic [31:0] mem_b [0:2047];
  logic [31:0] rd1_b, dout_b;
  always @(posedge clk) begin
    if (ena_b) begin
      if (wea_b) mem_b[addr_b] <= data_b;
      else       rd1_b <= mem_b[addr_b];
    end
    if (rsta_b)        dout_b <= '0;
    else if (regcea_b) dout_b <= rd1_b;
  end

  // Write logs sampled mid-cycle.
  wr_t log_b[$];
  wr_t log_s[$];
  always @(negedge clk) begin
    if (wea_b && ena_b) log_b.push_back(wr_t'{a: addr_b, d: data_b});
    if (wea_s && ena_s) log_s.push_back(wr_t'{a: 11'(addr_s), d: data_s});
  end

  // Reference model: group the byte stream into MSB-first words, stop at halt or at the last address.
  logic [7:0] bytes_q[$];
  wr_t        exp_q[$];
  logic [1:0] exp_err;

  function automatic void build_expected(input int depth);
    logic [31:0] w;
    exp_q.delete();
    exp_err = 2'b00;
    for (int i = 0; i * 4 + 3 < bytes_q.size(); i++) begin
      w = {bytes_q[i*4], bytes_q[i*4+1], bytes_q[i*4+2], bytes_q[i*4+3]};
      exp_q.push_back(wr_t'{a: 11'(i), d: w});
      if (w == 32'hFFFF_FFFF) break;
      if (i == depth - 1) begin
        exp_err = 2'b10;
        break;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int maxgap);
    foreach (bytes_q[i]) begin
      rx_data = bytes_q[i];
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat ($urandom_range(maxgap, 0)) tick();
    end
    rx_done = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    bytes_q.push_back(w[31:24]);
    bytes_q.push_back(w[23:16]);
    bytes_q.push_back(w[15:8]);
    bytes_q.push_back(w[7:0]);
  endtask

  task automatic start_load_b(output int n);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (soft_b === 1'b0 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_done_b(output bit ok);
    int n;
    n = 0;
    while (done_b !== 1'b1 && n < 300) begin
      n++;
      tick();
    end
    ok = (done_b === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_en = 1'b1;
    faddr_b = 11'd3;
    tick();
    tick();
    checks++; if (soft_b !== 1'b1) begin errors++; $display("FAIL reset_soft got %b exp 1", soft_b); end
    checks++; if ({wea_b, ena_b, regcea_b} !== 3'b000) begin errors++; $display("FAIL reset_wea_ena_regcea got %b exp 000", {wea_b, ena_b, regcea_b}); end
    checks++; if (rsta_b !== 1'b1) begin errors++; $display("FAIL reset_rsta got %b exp 1", rsta_b); end
    checks++; if (addr_b !== 11'd0 || data_b !== 32'd0) begin errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", addr_b, data_b); end
    checks++; if ({loading_b, done_b, err_b} !== 4'b0000 || wcnt_b !== 12'd0) begin errors++; $display("FAIL reset_status got %b cnt %0d exp 0000 cnt 0", {loading_b, done_b, err_b}, wcnt_b); end
    rst = 1'b0;
    tick();
    checks++; if (ena_b !== 1'b1 || addr_b !== 11'd3) begin errors++; $display("FAIL idle_fetch_mux got ena %b addr %0d exp 1 3", ena_b, addr_b); end
  endtask

  task automatic test_clear();
    int n;
    fetch_en = 1'b1;
    faddr_b = 11'd7;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++; if (soft_b !== 1'b0) begin errors++; $display("FAIL clear_soft_low got %b exp 0", soft_b); end
    checks++; if (ena_b !== 1'b0 || regcea_b !== 1'b0) begin errors++; $display("FAIL clear_fetch_ignored got ena %b regcea %b exp 0 0", ena_b, regcea_b); end
    checks++; if (rsta_b !== 1'b1 || loading_b !== 1'b1) begin errors++; $display("FAIL clear_rsta_loading got %b%b exp 11", rsta_b, loading_b); end
    fetch_en = 1'b0;
    n = 0;
    while (soft_b === 1'b0 && n < 50) begin
      n++;
      tick();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL clear_cycles got %0d exp 2", n); end
    checks++; if (loading_b !== 1'b1 || err_b !== 2'b00) begin errors++; $display("FAIL clear_to_load got loading %b err %b exp 1 00", loading_b, err_b); end
  endtask

  task automatic test_load_basic();
    bit ok;
    bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    build_expected(2048);
    log_b.delete();
    for (int i = 0; i < 8; i++) begin
      rx_data = bytes_q[i];
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      if (i == 3) begin
        checks++; if ({wea_b, ena_b} !== 2'b11 || addr_b !== 11'd0 || data_b !== 32'h1234_5678) begin errors++; $display("FAIL first_write got we/en %b addr %0d data %h exp 11 0 12345678", {wea_b, ena_b}, addr_b, data_b); end
      end
      tick();
      if (i == 3) begin
        checks++; if (wea_b !== 1'b0) begin errors++; $display("FAIL wea_one_cycle got %b exp 0", wea_b); end
      end
    end
    wait_done_b(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_run_timeout got done %b exp 1", done_b); end
    checks++; if (log_b.size() != exp_q.size()) begin errors++; $display("FAIL basic_write_count got %0d exp %0d", log_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_b.size(); i++) begin
      checks++; if (log_b[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write%0d got %h exp %h", i, log_b[i], exp_q[i]); end
    end
    checks++; if (wcnt_b !== 12'd2 || loading_b !== 1'b0 || err_b !== 2'b00) begin errors++; $display("FAIL basic_status got cnt %0d loading %b err %b exp 2 0 00", wcnt_b, loading_b, err_b); end
  endtask

  task automatic test_fetch();
    faddr_b = 11'd1;
    fetch_en = 1'b1;
    #1;
    checks++; if (addr_b !== 11'd1 || {ena_b, regcea_b, wea_b, rsta_b} !== 4'b1100) begin errors++; $display("FAIL run_fetch_mux got addr %0d e/r/w/rst %b exp 1 1100", addr_b, {ena_b, regcea_b, wea_b, rsta_b}); end
    tick();
    tick();
    checks++; if (dout_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fetch_read got %h exp ffffffff", dout_b); end
    fetch_en = 1'b0;
  endtask

  task automatic test_random_loads();
    int n;
    int nw;
    bit ok;
    logic [31:0] w;
    for (int it = 0; it < 4; it++) begin
      start_load_b(n);
      checks++; if (n != 2) begin errors++; $display("FAIL rnd%0d_clear got %0d exp 2", it, n); end
      bytes_q.delete();
      nw = $urandom_range(6, 1);
      for (int k = 0; k < nw; k++) begin
        do w = $urandom; while (w == 32'hFFFF_FFFF);
        push_word(w);
      end
      push_word(32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) bytes_q.push_back(8'($urandom));
      build_expected(2048);
      log_b.delete();
      send_bytes(2);
      wait_done_b(ok);
      repeat (3) tick();
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_run got done %b exp 1", it, done_b); end
      checks++; if (log_b.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_writes got %0d exp %0d", it, log_b.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < log_b.size(); i++) begin
        checks++; if (log_b[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_write%0d got %h exp %h", it, i, log_b[i], exp_q[i]); end
      end
      checks++; if (wcnt_b !== 12'(exp_q.size()) || err_b !== exp_err) begin errors++; $display("FAIL rnd%0d_status got cnt %0d err %b exp %0d %b", it, wcnt_b, err_b, exp_q.size(), exp_err); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    start_load_b(n);
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(0);
    checks++; if (wea_b !== 1'b1) begin errors++; $display("FAIL midwrite_pre got wea %b exp 1", wea_b); end
    rst = 1'b1;
    #1;
    checks++; if (wea_b !== 1'b0 || loading_b !== 1'b0) begin errors++; $display("FAIL midwrite_async got wea %b loading %b exp 0 0", wea_b, loading_b); end
    tick();
    rst = 1'b0;
    tick();
    start_load_b(n);
    bytes_q = '{8'h55, 8'h66};
    send_bytes(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    log_b.delete();
    start_load_b(n);
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_bytes(1);
    wait_done_b(ok);
    checks++; if (log_b.size() != 2) begin errors++; $display("FAIL partial_writes got %0d exp 2", log_b.size()); end
    if (log_b.size() > 0) begin
      checks++; if (log_b[0] !== wr_t'{a: 11'd0, d: 32'hAABB_CCDD}) begin errors++; $display("FAIL partial_discard got %h exp 000aabbccdd", log_b[0]); end
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] w;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n = 0;
    while (soft_s === 1'b0 && n < 50) begin
      n++;
      tick();
    end
    bytes_q.delete();
    for (int k = 0; k < 4; k++) begin
      do w = $urandom; while (w == 32'hFFFF_FFFF);
      push_word(w);
    end
    push_word($urandom);
    build_expected(4);
    log_s.delete();
    send_bytes(1);
    n = 0;
    while (done_s !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL ovf_run got done %b exp 1", done_s); end
    checks++; if (log_s.size() != exp_q.size()) begin errors++; $display("FAIL ovf_writes got %0d exp %0d", log_s.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_s.size(); i++) begin
      checks++; if (log_s[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_write%0d got %h exp %h", i, log_s[i], exp_q[i]); end
    end
    checks++; if (err_s !== exp_err || wcnt_s !== 3'(exp_q.size())) begin errors++; $display("FAIL ovf_status got err %b cnt %0d exp %b %0d", err_s, wcnt_s, exp_err, exp_q.size()); end
  endtask

  task automatic test_timeout();
    int n;
    stuck_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (loading_b === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    checks++; if (n != 4096) begin errors++; $display("FAIL timeout_cycles got %0d exp 4096", n); end
    checks++; if (err_b !== 2'b01 || soft_b !== 1'b1 || done_b !== 1'b0) begin errors++; $display("FAIL timeout_status got err %b soft %b done %b exp 01 1 0", err_b, soft_b, done_b); end
    stuck_b = 1'b0;
    faddr_b = 11'd5;
    fetch_en = 1'b1;
    #1;
    checks++; if (addr_b !== 11'd5 || ena_b !== 1'b1 || wea_b !== 1'b0) begin errors++; $display("FAIL timeout_idle_mux got addr %0d ena %b wea %b exp 5 1 0", addr_b, ena_b, wea_b); end
    fetch_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    start_b = 1'b0;
    start_s = 1'b0;
    stuck_b = 1'b0;
    faddr_b = '0;
    faddr_s = '0;
    test_reset();
    test_clear();
    test_load_basic();
    test_fetch();
    test_random_loads();
    test_reset_mid();
    test_overflow();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
